// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment scan controller: active-low segment
// codes ({g..a}), the blank pattern and a width helper.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n holds the active-low code for hex digit n.
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Bits needed to count 0..n-1, never less than 1.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << i) < n) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment code lookup.
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_CODES[nib_i];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 8-digit hex scanner for a common-anode, active-low
// 7-segment display. The displayed value is a shadow copy latched only at
// frame boundaries so a CPU store can never tear a frame.
// Optional: SEVEN_SEG_LEADING_ZERO_BLANK_EN keeps digits above the most
// significant nonzero nibble dark (digit 0 always lit).
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           display_data,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_start
);

  localparam int DIV_W = clog2(SCAN_DIV);
  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic                  primed_q;
  logic [31:0]           shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  fs_q, fs_d;
  logic                  load;
  logic [3:0]            nib;
  logic [6:0]            seg_code;
  logic                  digit_on;

  // Prescaler, digit counter and shadow load. The priming cycle right after
  // reset only loads the shadow; the prescaler starts on the next cycle so
  // every frame, including the first, spans NUM_DIGITS*SCAN_DIV cycles.
  always_comb begin
    load        = !primed_q || (div_cnt_q == DIV_LAST && digit_idx_q == IDX_LAST);
    div_cnt_d   = div_cnt_q;
    digit_idx_d = digit_idx_q;
    if (primed_q) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d   = '0;
        digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
    shadow_d = load ? display_data : shadow_q;
    fs_d     = load;
  end

  assign nib = shadow_q[{digit_idx_q, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .nib_i (nib),
    .seg_o (seg_code)
  );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd_idx;

  // Highest nonzero nibble of the shadow; zero when the value is zero.
  always_comb begin
    msd_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (shadow_q[4*i +: 4] != 4'h0) msd_idx = IDX_W'(i);
    digit_on = (digit_idx_q <= msd_idx);
  end
`else
  assign digit_on = 1'b1;
`endif

  // Anode/segment drive for the current slot: dark during the blanking
  // window at the start of each slot, otherwise one anode low.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    if (32'(div_cnt_q) >= BLANK_CYCLES && digit_on) begin
      an_d[digit_idx_q] = 1'b0;
      seg_d             = seg_code;
    end
  end

  // State and registered outputs; reset aborts any scan in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q   <= '0;
      digit_idx_q <= '0;
      primed_q    <= 1'b0;
      shadow_q    <= '0;
      an_q        <= '1;
      seg_q       <= SEG_OFF;
      fs_q        <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      primed_q    <= 1'b1;
      shadow_q    <= shadow_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      fs_q        <= fs_d;
    end
  end

  assign an_n        = an_q;
  assign seg_n       = seg_q;
  assign dp_n        = 1'b1;
  assign frame_start = fs_q;

endmodule
